// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Round-robin front end that shares one registered 8-bit signed ALU
//   (1-cycle latency) among NUM_REQ requesters. Each requester gets its own
//   held response slot, and only one op per requester can be outstanding.
//
// Ports
//   clock_in, reset_n_in         system clock, synchronous active-low reset
//   req_valid_in/req_ready_out   per-requester request handshake (ready is one-hot)
//   req_opcode_in, req_a_in,     packed per-requester opcode (3b) and signed
//   req_b_in                     operands (8b); requester i at slice i
//   resp_valid_out/resp_ready_in per-requester response slot handshake
//   resp_data_out, resp_err_out  held result / illegal-opcode flag per requester
//   alu_reset_out                ALU reset, combinational copy of ~reset_n_in
//   alu_enable_out, alu_opcode_out,
//   alu_input1_out, alu_input2_out   issue side of the shared ALU
//   alu_result_in                ALU registered output
module alu_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clock_in,
  input  logic                 reset_n_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  input  logic [3*NUM_REQ-1:0] req_opcode_in,
  input  logic [8*NUM_REQ-1:0] req_a_in,
  input  logic [8*NUM_REQ-1:0] req_b_in,
  output logic [NUM_REQ-1:0]   resp_valid_out,
  input  logic [NUM_REQ-1:0]   resp_ready_in,
  output logic [8*NUM_REQ-1:0] resp_data_out,
  output logic [NUM_REQ-1:0]   resp_err_out,
  output logic                 alu_reset_out,
  output logic                 alu_enable_out,
  output logic [2:0]           alu_opcode_out,
  output logic [7:0]           alu_input1_out,
  output logic [7:0]           alu_input2_out,
  input  logic [7:0]           alu_result_in
);

  logic [ID_W-1:0]    ptr;
  logic               tag_valid;
  logic               tag_err;
  logic [ID_W-1:0]    tag_id;
  logic [NUM_REQ-1:0] eligible;
  logic               grant;
  logic [ID_W-1:0]    grant_id;
  logic [31:0]        grant_sel;
  logic [31:0]        tag_sel;
  logic [2:0]         grant_op;
  logic               legal;

  // Index of the k-th requester after position p, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign alu_reset_out = ~reset_n_in;

  // The in-flight requester is excluded so its slot cannot be claimed twice
  // before the ALU result lands.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_in[i] & ~resp_valid_out[i] &
                    ~(tag_valid && (tag_id == ID_W'(i)));
    end
  end

  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant && eligible[wrap_idx(int'(ptr), k)]) begin
        grant    = 1'b1;
        grant_id = wrap_idx(int'(ptr), k);
      end
    end
    if (!reset_n_in) grant = 1'b0;
  end

  assign grant_sel = 32'(grant_id);
  assign tag_sel   = 32'(tag_id);
  assign grant_op  = req_opcode_in[3*grant_sel +: 3];
  assign legal     = (grant_op <= 3'd4);

  always_comb begin
    req_ready_out  = '0;
    alu_enable_out = 1'b0;
    alu_opcode_out = '0;
    alu_input1_out = '0;
    alu_input2_out = '0;
    if (grant) begin
      req_ready_out[grant_id] = 1'b1;
      // An illegal opcode is still granted (so the requester gets an error
      // response) but the ALU is left idle.
      alu_enable_out = legal;
      alu_opcode_out = grant_op;
      alu_input1_out = req_a_in[8*grant_sel +: 8];
      alu_input2_out = req_b_in[8*grant_sel +: 8];
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      ptr            <= ID_W'(NUM_REQ - 1);
      tag_valid      <= 1'b0;
      tag_err        <= 1'b0;
      tag_id         <= '0;
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      resp_err_out   <= '0;
    end else begin
      if (grant) begin
        ptr     <= grant_id;
        tag_id  <= grant_id;
        tag_err <= ~legal;
      end
      tag_valid <= grant;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid_out[i] && resp_ready_in[i]) begin
          resp_valid_out[i]       <= 1'b0;
          resp_data_out[8*i +: 8] <= '0;
          resp_err_out[i]         <= 1'b0;
        end
      end

      // The tagged slot was empty at grant time, so completion never
      // collides with a consume on the same slot.
      if (tag_valid) begin
        resp_valid_out[tag_id]        <= 1'b1;
        resp_data_out[8*tag_sel +: 8] <= tag_err ? 8'd0 : alu_result_in;
        resp_err_out[tag_id]          <= tag_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [3*N-1:0] req_opcode;
  logic [8*N-1:0] req_a, req_b, resp_data;
  logic           alu_reset, alu_enable;
  logic [2:0]     alu_opcode;
  logic [7:0]     alu_in1, alu_in2, alu_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clock_in(clk), .reset_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_opcode_in(req_opcode), .req_a_in(req_a), .req_b_in(req_b),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_data_out(resp_data), .resp_err_out(resp_err),
    .alu_reset_out(alu_reset), .alu_enable_out(alu_enable),
    .alu_opcode_out(alu_opcode), .alu_input1_out(alu_in1),
    .alu_input2_out(alu_in2), .alu_result_in(alu_result)
  );

  // Stand-in for the shared registered ALU.
  function automatic logic [7:0] alu_eval(logic [2:0] op, logic signed [7:0] a,
                                          logic signed [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = {7'b0, a == b};
      3'd4: r = {7'b0, a > b};
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (alu_reset) alu_result <= 8'd0;
    else if (alu_enable) alu_result <= alu_eval(alu_opcode, alu_in1, alu_in2);
  end

  // Reference model: each requester is FREE, BUSY (op accepted, result not
  // yet visible) or FULL (response visible), plus the last granted index.
  typedef enum {FREE, BUSY, FULL} slot_st_t;
  slot_st_t     st[N];
  int           exp_data[N];
  bit           exp_err[N];
  int           last = N - 1;
  int           exp_gnt;
  logic [N-1:0] exp_ready;
  logic         exp_en;

  function automatic int ref_result(int op, int a, int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = (a == b) ? 1 : 0;
      4: r = (a > b) ? 1 : 0;
      default: r = 0;
    endcase
    return r & 255;
  endfunction

  task automatic predict();
    exp_gnt = -1;
    if (rst_n) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if (exp_gnt < 0 && req_valid[i] && st[i] == FREE) exp_gnt = i;
      end
    end
    exp_ready = '0;
    exp_en = 1'b0;
    if (exp_gnt >= 0) begin
      exp_ready[exp_gnt] = 1'b1;
      exp_en = (req_opcode[3*exp_gnt +: 3] <= 3'd4);
    end
  endtask

  task automatic commit();
    if (!rst_n) begin
      for (int i = 0; i < N; i++) st[i] = FREE;
      last = N - 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (st[i] == FULL && resp_ready[i]) st[i] = FREE;
        else if (st[i] == BUSY) st[i] = FULL;
      end
      if (exp_gnt >= 0) begin
        int op, a, b;
        op = int'(req_opcode[3*exp_gnt +: 3]);
        a = $signed(req_a[8*exp_gnt +: 8]);
        b = $signed(req_b[8*exp_gnt +: 8]);
        st[exp_gnt] = BUSY;
        exp_err[exp_gnt] = (op > 4);
        exp_data[exp_gnt] = (op > 4) ? 0 : ref_result(op, a, b);
        last = exp_gnt;
      end
    end
  endtask

  task automatic look();
    @(negedge clk);
    predict();
  endtask

  task automatic tick();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) begin
      look();
      tick();
    end
  endtask

  task automatic set_req(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    req_opcode[3*i +: 3] = op;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'($urandom);
    resp_ready = '1;
    for (int c = 0; c < 3; c++) begin
      look();
      checks++;
      if (req_ready !== 4'b0) begin
        failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      checks++;
      if (alu_enable !== 1'b0 || alu_reset !== 1'b1) begin
        failures++; $display("FAIL reset_alu: enable=%b reset=%b expected 0 1", alu_enable, alu_reset);
      end
      if (c > 0) begin
        checks++;
        if (resp_valid !== 4'b0 || resp_data !== 32'b0 || resp_err !== 4'b0) begin
          failures++;
          $display("FAIL reset_resp: valid=%b data=%h err=%b expected all zero", resp_valid, resp_data, resp_err);
        end
      end
      tick();
    end
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    set_req(0, 3'd0, 8'd5, 8'd3);
    look();
    checks++;
    if (req_ready !== 4'b0001 || alu_enable !== 1'b1) begin
      failures++; $display("FAIL single_grant: ready=%b en=%b expected 0001 1", req_ready, alu_enable);
    end
    checks++;
    if (alu_opcode !== 3'd0 || alu_in1 !== 8'd5 || alu_in2 !== 8'd3) begin
      failures++; $display("FAIL single_issue: op=%0d a=%0d b=%0d expected 0 5 3", alu_opcode, alu_in1, alu_in2);
    end
    tick();
    req_valid = '0;
    look();
    checks++;
    if (resp_valid !== 4'b0) begin
      failures++; $display("FAIL single_latency: resp_valid=%b at T+1 expected 0000", resp_valid);
    end
    tick();
    look();
    checks++;
    if (resp_valid !== 4'b0001 || resp_data[7:0] !== 8'd8 || resp_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: valid=%b data=%0d err=%b expected 0001 8 0", resp_valid, resp_data[7:0], resp_err[0]);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [7:0] expv [4];
    logic [3:0] er;
    expv[0] = 8'h80; expv[1] = 8'h7F; expv[2] = 8'h01; expv[3] = 8'h00;
    rst_n = 1'b0;
    look();
    tick();
    rst_n = 1'b1;
    set_req(0, 3'd2, 8'd16, 8'd8);
    set_req(1, 3'd1, 8'h80, 8'd1);
    set_req(2, 3'd3, 8'd7, 8'd7);
    set_req(3, 3'd4, 8'hFF, 8'd1);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      look();
      if (c < 4) begin
        er = 4'b0001 << c;
        checks++;
        if (req_ready !== er) begin
          failures++; $display("FAIL simul_grant%0d: got %b expected %b", c, req_ready, er);
        end
      end
      if (c >= 2) begin
        checks++;
        if (resp_valid[c-2] !== 1'b1 || resp_data[8*(c-2) +: 8] !== expv[c-2] || resp_err[c-2] !== 1'b0) begin
          failures++;
          $display("FAIL simul_resp%0d: valid=%b data=%h err=%b expected 1 %h 0",
                   c - 2, resp_valid[c-2], resp_data[8*(c-2) +: 8], resp_err[c-2], expv[c-2]);
        end
      end
      tick();
      if (c < 4) req_valid[c] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int n0 = 0, n2 = 0, nother = 0, prev = -1;
    set_req(0, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
    set_req(2, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
    resp_ready = 4'b1111;
    req_valid = 4'b0101;
    for (int c = 0; c < 15; c++) begin
      look();
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL fair_grant: cycle %0d got %b expected %b", c, req_ready, exp_ready);
      end
      if (req_ready == 4'b0001 || req_ready == 4'b0100) begin
        int g;
        g = (req_ready == 4'b0001) ? 0 : 2;
        if (prev >= 0) begin
          checks++;
          if (g == prev) begin
            failures++; $display("FAIL fair_order: granted %0d twice in a row, expected alternation", g);
          end
        end
        prev = g;
        if (g == 0) n0++; else n2++;
      end else if (req_ready != 4'b0000) nother++;
      tick();
    end
    checks++;
    if (n0 < 4 || n2 < 4 || nother != 0) begin
      failures++; $display("FAIL fair_counts: n0=%0d n2=%0d other=%0d expected >=4 >=4 0", n0, n2, nother);
    end
    req_valid = '0;
    idle(4);
  endtask

  task automatic test_backpressure();
    int n3 = 0;
    bit seen = 0;
    logic [7:0] held = 8'd0;
    set_req(1, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
    set_req(3, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
    resp_ready = 4'b1101;
    req_valid = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      look();
      checks++;
      if (req_ready !== exp_ready) begin
        failures++; $display("FAIL bp_grant: cycle %0d got %b expected %b", c, req_ready, exp_ready);
      end
      if (req_ready[3]) n3++;
      if (resp_valid[1]) begin
        checks++;
        if (req_ready[1] !== 1'b0) begin
          failures++; $display("FAIL bp_regrant: req1 ready=%b while slot full, expected 0", req_ready[1]);
        end
        checks++;
        if (resp_data[15:8] !== 8'(exp_data[1]) || (seen && resp_data[15:8] !== held)) begin
          failures++;
          $display("FAIL bp_hold: data=%h expected %h", resp_data[15:8], 8'(exp_data[1]));
        end
        seen = 1;
        held = resp_data[15:8];
      end
      tick();
    end
    checks++;
    if (!seen || n3 < 1) begin
      failures++; $display("FAIL bp_progress: resp1_seen=%0d req3_grants=%0d expected 1 >=1", seen, n3);
    end
    req_valid = 4'b0010;
    resp_ready = 4'b1111;
    look();
    checks++;
    if (resp_valid[1] !== 1'b1 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL bp_release: valid1=%b ready=%b expected 1 0000", resp_valid[1], req_ready);
    end
    tick();
    look();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_regrant_after: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    idle(4);
  endtask

  task automatic test_illegal();
    set_req(2, 3'b111, 8'($urandom), 8'($urandom));
    req_valid = 4'b0100;
    look();
    checks++;
    if (req_ready !== 4'b0100 || alu_enable !== 1'b0) begin
      failures++; $display("FAIL illegal_grant: ready=%b en=%b expected 0100 0", req_ready, alu_enable);
    end
    tick();
    req_valid = '0;
    look();
    tick();
    look();
    checks++;
    if (resp_valid[2] !== 1'b1 || resp_data[23:16] !== 8'd0 || resp_err[2] !== 1'b1) begin
      failures++;
      $display("FAIL illegal_resp: valid=%b data=%h err=%b expected 1 00 1", resp_valid[2], resp_data[23:16], resp_err[2]);
    end
    tick();
    idle(2);
  endtask

  task automatic test_reset_midflight();
    set_req(1, 3'd0, 8'($urandom), 8'($urandom));
    req_valid = 4'b0010;
    look();
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL midrst_grant: got %b expected 0010", req_ready);
    end
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    look();
    checks++;
    if (alu_reset !== 1'b1 || req_ready !== 4'b0 || alu_enable !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: alu_reset=%b ready=%b en=%b expected 1 0000 0", alu_reset, req_ready, alu_enable);
    end
    tick();
    rst_n = 1'b1;
    look();
    checks++;
    if (resp_valid !== 4'b0) begin
      failures++; $display("FAIL midrst_dropped: resp_valid=%b expected 0000", resp_valid);
    end
    tick();
    req_valid = 4'b1101;
    look();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL midrst_first: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    idle(4);
  endtask

  task automatic test_random();
    logic [N-1:0] ev;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      req_valid = 4'($urandom);
      resp_ready = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        logic [2:0] op;
        op = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        set_req(i, op, 8'($urandom), 8'($urandom));
      end
      look();
      checks++;
      if (req_ready !== exp_ready || alu_enable !== exp_en || alu_reset !== ~rst_n) begin
        failures++;
        $display("FAIL rand_ctrl: cycle %0d ready=%b en=%b rst=%b expected %b %b %b",
                 c, req_ready, alu_enable, alu_reset, exp_ready, exp_en, ~rst_n);
      end
      checks++;
      if (exp_gnt >= 0) begin
        if (alu_opcode !== req_opcode[3*exp_gnt +: 3] || alu_in1 !== req_a[8*exp_gnt +: 8] ||
            alu_in2 !== req_b[8*exp_gnt +: 8]) begin
          failures++; $display("FAIL rand_issue: cycle %0d op=%0d a=%h b=%h for req %0d", c, alu_opcode, alu_in1, alu_in2, exp_gnt);
        end
      end else if (alu_opcode !== 3'd0 || alu_in1 !== 8'd0 || alu_in2 !== 8'd0) begin
        failures++; $display("FAIL rand_idle: cycle %0d op=%0d a=%h b=%h expected zeros", c, alu_opcode, alu_in1, alu_in2);
      end
      ev = '0;
      for (int i = 0; i < N; i++) ev[i] = (st[i] == FULL);
      checks++;
      if (resp_valid !== ev) begin
        failures++; $display("FAIL rand_valid: cycle %0d got %b expected %b", c, resp_valid, ev);
      end
      for (int i = 0; i < N; i++) begin
        if (st[i] == FULL) begin
          checks++;
          if (resp_data[8*i +: 8] !== 8'(exp_data[i]) || resp_err[i] !== exp_err[i]) begin
            failures++;
            $display("FAIL rand_data%0d: cycle %0d data=%h err=%b expected %h %b",
                     i, c, resp_data[8*i +: 8], resp_err[i], 8'(exp_data[i]), exp_err[i]);
          end
        end
      end
      tick();
    end
    rst_n = 1'b1;
    req_valid = '0;
    resp_ready = '1;
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '1;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      st[i] = FREE;
      exp_data[i] = 0;
      exp_err[i] = 0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
